i2s_pattern_src: RTL and testbench
==================================

# i2s_pattern_src

Synthesisable, parametrised I2S slave transmitter that generates test audio patterns (constant, ramp, square, pseudo-random) on DIN in response to the BCLK/WS driven by the SoC's I2S master. It replaces the fixed-pattern simulation stimulus with a configurable block usable both in benches and on FPGA, in front of the SoC's `I2S_in` pin. All logic runs on HCLK; BCLK and WS are treated as asynchronous inputs.

## Interface
- SAMPLE_W, 24, sample width in bits (1..32), MSB-first
- INVERT_RIGHT, 1, 1: right sample = bitwise NOT of left; 0: right = left
- LFSR_SEED, 32'hACE1_1234, LFSR reset value (must be non-zero)

- HCLK  in  1  system clock
- HRESET  in  1  asynchronous, active-high reset
- en  in  1  enable; transmission starts at a frame boundary
- mode  in  2  0 constant, 1 ramp, 2 square, 3 LFSR
- const_val  in  SAMPLE_W  constant / square amplitude
- step  in  SAMPLE_W  ramp increment per frame
- bclk  in  1  I2S bit clock from master
- ws  in  1  I2S word select from master (0 = left)
- din  out  1  serial data to master
- active  out  1  high while frames are being transmitted
- frame_cnt  out  16  frames sent since reset, wraps at 0xFFFF
- short_slot  out  1  sticky: a slot ended before SAMPLE_W bits were sent

## Operation
- bclk, ws: two-flop synchronisers; edge detect on synchronised bclk (rise/fall pulses, one HCLK each).
- On bclk rise: ws_r <= ws_sync.
- On bclk fall: compare ws_r with ws_last (ws_r captured at previous fall); ws_last <= ws_r.
- States: IDLE, SHIFT.
- IDLE: din = 0. On a fall with ws_r != ws_last and ws_r == 0 and en == 1 -> load left sample, drive MSB, go SHIFT, active = 1.
- SHIFT, fall with WS change: if bits_sent < SAMPLE_W, set short_slot. Load sample for channel ws_r, drive its MSB, bit_idx = 1.
- SHIFT, fall without WS change: drive bit SAMPLE_W-1-bit_idx, bit_idx++. Once bit_idx >= SAMPLE_W, drive 0 (pad), bit_idx saturates.
- Result: MSB appears one BCLK after the WS transition (I2S standard). Receiver samples on rising edge.
- Frame generation, only at left loads:
  - mode and en are sampled here.
  - frame_cnt increments when the left load completes a previous frame.
  - Sample value by mode:
    - mode 0: const_val.
    - mode 1: acc; then acc <= acc + step, modulo 2^SAMPLE_W.
    - mode 2: alternates const_val, -const_val (two's complement) on successive frames, starting +.
    - mode 3: top SAMPLE_W bits of a 32-bit Galois LFSR (poly x^32+x^22+x^2+x+1), stepped once per frame.
  - Right sample = left or ~left per INVERT_RIGHT. It is latched at the left load so both channels come from the same frame.
- en low at a left load: go IDLE, din = 0, active = 0. Generators hold their state.
- en deasserted mid-frame: the current frame finishes. Stop at the next left load.

## Timing
- Reset values: din 0, active 0, frame_cnt 0, short_slot 0, acc 0, LFSR = LFSR_SEED, square phase +, state IDLE, ws_last 0.
- din updates exactly 3 HCLK after the bclk falling edge at the pin (2 sync + 1 register).
- bclk high and low must each last >= 4 HCLK; ws must be stable around bclk rise.
- Slots longer than SAMPLE_W are zero-padded. Shorter slots are truncated and set short_slot, which clears only on reset.
- Reset asserted mid-frame: all state returns to reset values immediately. din = 0 until the next left-frame start with en = 1.
- WS toggling while IDLE with ws going 0->1: no start (start only on left).
- mode change mid-frame: takes effect at the next left load only.

## Test plan
- mode 0, const_val=24'hA5A5A5, INVERT_RIGHT=1, BCLK = HCLK/8, 32-bit slots -> captured left = A5A5A5, right = 5A5A5A, 8 pad zeros per slot, frame_cnt increments per frame.
- mode 1, step=3, 4 frames -> left samples 0, 3, 6, 9. With step=24'hFFFFFF from acc=1, the next sample is 0 (wrap).
- mode 2, const_val=100 -> left alternates 100, 0xFFFF9C, 100, ...
- 16-bit slots with SAMPLE_W=24 -> only top 16 bits are sent and short_slot = 1. A later 32-bit slot run leaves short_slot = 1.
- en rises while ws=1 -> din stays 0 until the first left start, then MSB appears one BCLK after ws falls. en drops mid-right slot -> right completes, then active = 0 and din = 0.
- HRESET pulsed mid-left-slot in mode 3 -> din = 0 within 1 HCLK. After restart, the first sample equals the top bits of LFSR_SEED.

Source files
------------

// File: rtl/i2s_pattern_src_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pattern_src_if
// Purpose  : I2S serial lines between the SoC master (BCLK/WS) and the source.
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_pattern_src_if;
    logic bclk;
    logic ws;
    logic din;

    modport master (output bclk, output ws, input din);
    modport slave  (input bclk, input ws, output din);
endinterface
`default_nettype wire

// File: rtl/i2s_pattern_src.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pattern_src
// Purpose  : I2S slave transmitter producing constant/ramp/square/LFSR patterns.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_pattern_src #(
    parameter int          SAMPLE_W     = 24,
    parameter bit          INVERT_RIGHT = 1'b1,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_1234
) (
    input  wire logic                HCLK,
    input  wire logic                HRESET,
    input  wire logic                en,
    input  wire logic [1:0]          mode,
    input  wire logic [SAMPLE_W-1:0] const_val,
    input  wire logic [SAMPLE_W-1:0] step,
    i2s_pattern_src_if.slave         i2s,
    output logic                     active,
    output logic [15:0]              frame_cnt,
    output logic                     short_slot
);
    localparam int              c_BW        = $clog2(SAMPLE_W + 1);
    localparam logic [c_BW-1:0] c_BITS_FULL = c_BW'(SAMPLE_W);
    localparam logic [31:0]     c_LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_bclk_m, r_bclk_s, r_bclk_d;
    logic r_ws_m, r_ws_s;
    logic r_ws_r, r_ws_last;

    logic                r_din;
    logic [SAMPLE_W-1:0] r_sh;
    logic [SAMPLE_W-1:0] r_right;
    logic [c_BW-1:0]     r_bit_idx;
    logic [15:0]         r_frame_cnt;
    logic                r_short;
    logic [SAMPLE_W-1:0] r_acc;
    logic [31:0]         r_lfsr;
    logic                r_sq_neg;

    logic w_rise, w_fall, w_ws_chg, w_left_edge, w_right_edge;
    logic w_load_left, w_load_right, w_shift, w_frame_done, w_stop;
    logic [SAMPLE_W-1:0] w_left;
    logic [31:0]         w_lfsr_next;

    // BCLK and WS are asynchronous to HCLK; the third bclk flop only feeds edge detection.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_bclk_m <= 1'b0;
            r_bclk_s <= 1'b0;
            r_bclk_d <= 1'b0;
            r_ws_m   <= 1'b0;
            r_ws_s   <= 1'b0;
        end else begin
            r_bclk_m <= i2s.bclk;
            r_bclk_s <= r_bclk_m;
            r_bclk_d <= r_bclk_s;
            r_ws_m   <= i2s.ws;
            r_ws_s   <= r_ws_m;
        end
    end

    assign w_rise       = r_bclk_s & ~r_bclk_d;
    assign w_fall       = ~r_bclk_s & r_bclk_d;
    assign w_ws_chg     = w_fall && (r_ws_r != r_ws_last);
    assign w_left_edge  = w_ws_chg && !r_ws_r;
    assign w_right_edge = w_ws_chg && r_ws_r;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load_left  = 1'b0;
        w_load_right = 1'b0;
        w_shift      = 1'b0;
        w_frame_done = 1'b0;
        w_stop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_left_edge && en) begin
                    w_load_left  = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_left_edge) begin
                    w_frame_done = 1'b1;
                    if (en) begin
                        w_load_left = 1'b1;
                    end else begin
                        w_stop       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end else if (w_right_edge) begin
                    w_load_right = 1'b1;
                end else if (w_fall) begin
                    w_shift = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_LFSR_TAPS : 32'h0);

    always_comb begin
        w_left = const_val;
        case (mode)
            2'd1:    w_left = r_acc;
            2'd2:    w_left = r_sq_neg ? (SAMPLE_W'(0) - const_val) : const_val;
            2'd3:    w_left = r_lfsr[31 -: SAMPLE_W];
            default: w_left = const_val;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_ws_r      <= 1'b0;
            r_ws_last   <= 1'b0;
            r_din       <= 1'b0;
            r_sh        <= '0;
            r_right     <= '0;
            r_bit_idx   <= '0;
            r_frame_cnt <= '0;
            r_short     <= 1'b0;
            r_acc       <= '0;
            r_lfsr      <= LFSR_SEED;
            r_sq_neg    <= 1'b0;
        end else begin
            if (w_rise) r_ws_r    <= r_ws_s;
            if (w_fall) r_ws_last <= r_ws_r;
            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_ws_chg && (r_state == ST_SHIFT) && (r_bit_idx < c_BITS_FULL))
                r_short <= 1'b1;

            if (w_load_left) begin
                // Right word is frozen here so both channels belong to the same frame.
                r_right   <= INVERT_RIGHT ? ~w_left : w_left;
                r_din     <= w_left[SAMPLE_W-1];
                r_sh      <= w_left << 1;
                r_bit_idx <= c_BW'(1);
                case (mode)
                    2'd1:    r_acc    <= r_acc + step;
                    2'd2:    r_sq_neg <= ~r_sq_neg;
                    2'd3:    r_lfsr   <= w_lfsr_next;
                    default: ;
                endcase
            end else if (w_load_right) begin
                r_din     <= r_right[SAMPLE_W-1];
                r_sh      <= r_right << 1;
                r_bit_idx <= c_BW'(1);
            end else if (w_shift) begin
                if (r_bit_idx < c_BITS_FULL) begin
                    r_din     <= r_sh[SAMPLE_W-1];
                    r_sh      <= r_sh << 1;
                    r_bit_idx <= r_bit_idx + c_BW'(1);
                end else begin
                    r_din <= 1'b0;
                end
            end else if (w_stop) begin
                r_din <= 1'b0;
            end
        end
    end

    assign i2s.din    = r_din;
    assign active     = (r_state == ST_SHIFT);
    assign frame_cnt  = r_frame_cnt;
    assign short_slot = r_short;

endmodule
`default_nettype wire

// File: tb/tb_i2s_pattern_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_pattern_src
// Purpose  : Randomised bench for i2s_pattern_src with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_pattern_src;
    localparam int          SW   = 24;
    localparam int          HALF = 40;
    localparam logic [31:0] SEED = 32'hACE1_1234;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [SW-1:0] const_val = '0;
    logic [SW-1:0] step = '0;
    logic          active;
    logic [15:0]   frame_cnt;
    logic          short_slot;

    i2s_pattern_src_if bus();

    i2s_pattern_src #(.SAMPLE_W(SW), .INVERT_RIGHT(1'b1), .LFSR_SEED(SEED)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .en         (en),
        .mode       (mode),
        .const_val  (const_val),
        .step       (step),
        .i2s        (bus),
        .active     (active),
        .frame_cnt  (frame_cnt),
        .short_slot (short_slot)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    // Frame-level reference state
    logic [SW-1:0] m_acc;
    logic [31:0]   m_lfsr;
    bit            m_neg;
    logic [15:0]   m_cnt;
    bit            m_active;
    logic [SW-1:0] m_right;

    logic          q[$];
    logic [SW-1:0] got_left[$];

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic [31:0] r;
        int taps[4] = '{32, 22, 2, 1};
        r = s >> 1;
        if (s[0]) foreach (taps[i]) r[taps[i]-1] = ~r[taps[i]-1];
        return r;
    endfunction

    function automatic logic [SW-1:0] word_at(input int st, input int n);
        logic [SW-1:0] w;
        w = '0;
        for (int j = 1; j <= n; j++) w = {w[SW-2:0], q[st+j]};
        return w;
    endfunction

    function automatic int ones_in(input int st, input int from, input int to);
        int c;
        c = 0;
        for (int j = from; j <= to; j++) if (q[st+j] !== 1'b0) c++;
        return c;
    endfunction

    task automatic model_reset();
        m_acc = '0; m_lfsr = SEED; m_neg = 0; m_cnt = '0; m_active = 0; m_right = '0;
    endtask

    task automatic model_left(output logic [SW-1:0] l, output bit loaded);
        if (m_active) m_cnt++;
        loaded = en;
        l = '0;
        if (!en) begin
            m_active = 0;
        end else begin
            m_active = 1;
            case (mode)
                2'd0: l = const_val;
                2'd1: begin l = m_acc; m_acc = m_acc + step; end
                2'd2: begin l = m_neg ? (SW'(0) - const_val) : const_val; m_neg = !m_neg; end
                default: begin l = m_lfsr[31 -: SW]; m_lfsr = lfsr_adv(m_lfsr); end
            endcase
            m_right = ~l;
        end
    endtask

    task automatic cyc(input bit wsv);
        bus.bclk = 1'b0;
        bus.ws   = wsv;
        #HALF;
        bus.bclk = 1'b1;
        q.push_back(bus.din);
        #HALF;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        #(2*HALF);
        HRESET = 1'b0;
        #(2*HALF);
        model_reset();
    endtask

    // Runs nf frames of len-bit slots with en held high, then checks every slot.
    task automatic xfer(input int nf, input int len);
        logic [SW-1:0] expw[$];
        int st[$];
        logic [SW-1:0] l, w;
        bit ld;
        int n;
        q.delete();
        got_left.delete();
        cyc(1); cyc(1);
        for (int f = 0; f < nf; f++) begin
            model_left(l, ld);
            expw.push_back(l);
            expw.push_back(m_right);
            st.push_back(q.size()); repeat (len) cyc(0);
            st.push_back(q.size()); repeat (len) cyc(1);
        end
        cyc(1);
        n = (len < SW) ? len : SW;
        foreach (st[k]) begin
            w = word_at(st[k], n);
            if (k % 2 == 0) got_left.push_back(w);
            total++;
            if (w !== (expw[k] >> (SW - n))) begin
                bad++;
                $display("FAIL slot_word[%0d] got=%h want=%h", k, w, expw[k] >> (SW - n));
            end
            total++;
            if (ones_in(st[k], n + 1, len) != 0) begin
                bad++;
                $display("FAIL slot_pad[%0d] got=%0d ones want=0", k, ones_in(st[k], n + 1, len));
            end
        end
        total++;
        if (frame_cnt !== m_cnt) begin
            bad++;
            $display("FAIL frame_cnt got=%0d want=%0d", frame_cnt, m_cnt);
        end
        total++;
        if (active !== m_active) begin
            bad++;
            $display("FAIL active got=%b want=%b", active, m_active);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.din !== 1'b0)  begin bad++; $display("FAIL reset_din got=%b want=0", bus.din); end
        total++; if (active !== 1'b0)   begin bad++; $display("FAIL reset_active got=%b want=0", active); end
        total++; if (frame_cnt !== 0)   begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
        total++; if (short_slot !== 0)  begin bad++; $display("FAIL reset_short got=%b want=0", short_slot); end
    endtask

    task automatic test_const();
        logic [31:0] rv;
        do_reset();
        mode = 2'd0; const_val = 24'hA5A5A5; en = 1'b1;
        xfer(3, 32);
        total++; if (got_left[0] !== 24'hA5A5A5) begin bad++; $display("FAIL const_left got=%h want=a5a5a5", got_left[0]); end
        rv = $urandom();
        const_val = rv[SW-1:0];
        xfer(2, 32);
    endtask

    task automatic test_ramp();
        logic [SW-1:0] want[4] = '{24'd0, 24'd3, 24'd6, 24'd9};
        do_reset();
        mode = 2'd1; step = 24'd3; en = 1'b1;
        xfer(4, 32);
        foreach (want[i]) begin
            total++;
            if (got_left[i] !== want[i]) begin bad++; $display("FAIL ramp[%0d] got=%h want=%h", i, got_left[i], want[i]); end
        end
        do_reset();
        step = 24'd1;
        xfer(1, 32);
        step = 24'hFFFFFF;
        xfer(2, 32);
        total++; if (got_left[1] !== 24'd0) begin bad++; $display("FAIL ramp_wrap got=%h want=000000", got_left[1]); end
    endtask

    task automatic test_square();
        do_reset();
        mode = 2'd2; const_val = 24'd100; en = 1'b1;
        xfer(3, 32);
        total++; if (got_left[1] !== 24'hFFFF9C) begin bad++; $display("FAIL square_neg got=%h want=ffff9c", got_left[1]); end
        total++; if (got_left[2] !== 24'd100)    begin bad++; $display("FAIL square_pos got=%h want=000064", got_left[2]); end
    endtask

    task automatic test_short();
        logic [31:0] rv;
        do_reset();
        rv = $urandom();
        mode = 2'd0; const_val = rv[SW-1:0]; en = 1'b1;
        xfer(2, 16);
        total++; if (short_slot !== 1'b1) begin bad++; $display("FAIL short_set got=%b want=1", short_slot); end
        xfer(2, 32);
        total++; if (short_slot !== 1'b1) begin bad++; $display("FAIL short_sticky got=%b want=1", short_slot); end
    endtask

    task automatic test_enable();
        logic [SW-1:0] l, rexp;
        bit ld;
        int s, rs, s2;
        do_reset();
        mode = 2'd0; const_val = 24'hA5A5A5; en = 1'b0;
        q.delete();
        repeat (3) cyc(1);
        en = 1'b1;
        repeat (3) cyc(1);
        total++;
        if (ones_in(-1, 1, q.size()) != 0 || active !== 1'b0) begin
            bad++; $display("FAIL idle_quiet got=%0d ones active=%b want=0", ones_in(-1, 1, q.size()), active);
        end
        model_left(l, ld);
        rexp = m_right;
        s = q.size();  repeat (32) cyc(0);
        rs = q.size(); repeat (16) cyc(1);
        en = 1'b0;     repeat (16) cyc(1);
        model_left(l, ld);
        s2 = q.size(); repeat (32) cyc(0);
        cyc(1);
        total++; if (q[s] !== 1'b0) begin bad++; $display("FAIL msb_delay got=%b want=0", q[s]); end
        total++; if (word_at(s, SW) !== 24'hA5A5A5) begin bad++; $display("FAIL en_left got=%h want=a5a5a5", word_at(s, SW)); end
        total++; if (word_at(rs, SW) !== rexp) begin bad++; $display("FAIL en_right got=%h want=%h", word_at(rs, SW), rexp); end
        total++; if (ones_in(s2, 1, 32) != 0) begin bad++; $display("FAIL stop_din got=%0d ones want=0", ones_in(s2, 1, 32)); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL stop_active got=%b want=0", active); end
        total++; if (frame_cnt !== m_cnt) begin bad++; $display("FAIL stop_cnt got=%0d want=%0d", frame_cnt, m_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [SW-1:0] l;
        bit ld;
        int j;
        do_reset();
        mode = 2'd3; en = 1'b1;
        xfer(1, 32);
        model_left(l, ld);
        j = 0;
        for (int b = 0; b < SW; b++) if (l[SW-1-b] && j == 0) j = b;
        repeat (j + 2) cyc(0);
        total++; if (bus.din !== l[SW-1-j]) begin bad++; $display("FAIL pre_reset_din got=%b want=%b", bus.din, l[SW-1-j]); end
        #20;
        HRESET = 1'b1;
        #1;
        total++; if (bus.din !== 1'b0) begin bad++; $display("FAIL mid_reset_din got=%b want=0", bus.din); end
        total++; if (active !== 1'b0 || frame_cnt !== 0) begin bad++; $display("FAIL mid_reset_state got=%b/%0d want=0/0", active, frame_cnt); end
        #59;
        HRESET = 1'b0;
        model_reset();
        xfer(2, 32);
        total++; if (got_left[0] !== SEED[31 -: SW]) begin bad++; $display("FAIL lfsr_seed got=%h want=%h", got_left[0], SEED[31 -: SW]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rv;
        do_reset();
        en = 1'b1;
        for (int it = 0; it < 6; it++) begin
            mode = 2'($urandom_range(0, 3));
            rv = $urandom(); const_val = rv[SW-1:0];
            rv = $urandom(); step = rv[SW-1:0];
            xfer($urandom_range(1, 3), $urandom_range(SW, 32));
        end
        total++; if (short_slot !== 1'b0) begin bad++; $display("FAIL no_short got=%b want=0", short_slot); end
    endtask

    initial begin
        #(64'd20_000_000);
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        bus.bclk = 1'b1;
        bus.ws   = 1'b0;
        @(posedge HCLK);
        #3;
        test_reset();
        test_const();
        test_ramp();
        test_square();
        test_short();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
